// File: rtl/rr_credit_arbiter.sv
// -----------------------------------------------------------------------------
// rr_credit_arbiter
//
// Output-port arbiter for one output of the 5-port mesh router
// (ports L=0, N=1, E=2, W=3, S=4). It grants the output to one input port
// per packet in round-robin order and holds the grant from the header flit
// through the tail flit (wormhole ownership). Flits are forwarded only while
// the downstream buffer has credits.
//
// Parameters:
//   CREDITS  downstream buffer depth; credit counter reset value and ceiling (1..15)
//   TIMEOUT  watchdog limit in stalled cycles (1..4095); used only when the
//            watchdog is compiled in
//
// Optional feature: define ARB_WATCHDOG_EN to build the stall watchdog.
// Without it, drop is tied low and a lock lasts until its tail is forwarded.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   req[4:0]    bit i: input port i has a valid flit at its buffer head
//   flit_id     3-bit flit type per port, port i at [3i+2:3i]
//               001 header, 010 body, 100 tail, 101 single-flit packet
//   credit_in   downstream freed one slot this cycle
//   grant[4:0]  one-hot owner of the output port, zero when idle
//   sel[2:0]    encoded owner for the crossbar mux, zero when idle
//   fwd         a flit transfers from the owner this cycle (combinational)
//   credits     current credit count
//   busy        a packet currently owns the output
//   credit_err  sticky: credit_in arrived while the count was already full
//   drop        one-cycle pulse: the watchdog released a stalled lock
// -----------------------------------------------------------------------------
module rr_credit_arbiter #(
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req,
    input  logic [14:0] flit_id,
    input  logic        credit_in,
    output logic [4:0]  grant,
    output logic [2:0]  sel,
    output logic        fwd,
    output logic [3:0]  credits,
    output logic        busy,
    output logic        credit_err,
    output logic        drop
);

    // Reject configurations the counters cannot represent.
    if (CREDITS < 1 || CREDITS > 15) begin : g_bad_credits
        $error("rr_credit_arbiter: CREDITS must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 4095) begin : g_bad_timeout
        $error("rr_credit_arbiter: TIMEOUT must be 1..4095");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [2:0] owner, owner_next;
    logic [2:0] last_winner, last_winner_next;

    logic [4:0] eligible;
    logic [2:0] winner;
    logic       owner_req;
    logic       owner_tail;
    logic       wd_fire;

    // The body bit of each flit type never changes a decision: headers are
    // recognised by bit 0 and packet ends by bit 2.
    logic unused_body_bits;
    assign unused_body_bits = ^{flit_id[13], flit_id[10], flit_id[7], flit_id[4], flit_id[1]};

    // Only header flits may open a new packet.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            eligible[i] = req[i] & flit_id[3*i];
        end
    end

    // Round-robin pick: scan from last_winner+1 around the ring. The scan runs
    // backwards so the last assignment is the first eligible port in order.
    always_comb begin : pick_winner
        logic [3:0] sum;
        logic [2:0] idx;
        // NOTE: every variable written in a combinational block gets a default
        // before any conditional assignment, otherwise a latch is inferred.
        winner = 3'd0;
        sum    = 4'd0;
        idx    = 3'd0;
        for (int k = 5; k >= 1; k--) begin
            sum = {1'b0, last_winner} + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (eligible[idx]) begin
                winner = idx;
            end
        end
    end

    // Owner's request and whether its head flit ends the packet.
    always_comb begin
        owner_req  = 1'b0;
        owner_tail = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (owner == 3'(i)) begin
                owner_req  = req[i];
                owner_tail = flit_id[3*i+2];
            end
        end
    end

    assign busy  = (state == LOCKED);
    assign grant = busy ? (5'b00001 << owner) : 5'b00000;
    assign sel   = busy ? owner : 3'd0;
    assign fwd   = busy & owner_req & (credits != 4'd0);

    // Next-state logic. A header from the owner while locked is forwarded like
    // a body flit because only bit 2 ends the packet.
    always_comb begin
        state_next       = state;
        owner_next       = owner;
        last_winner_next = last_winner;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_next = LOCKED;
                    owner_next = winner;
                end
            end
            LOCKED: begin
                if (wd_fire || (fwd && owner_tail)) begin
                    state_next       = IDLE;
                    last_winner_next = owner;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            owner       <= 3'd0;
            last_winner <= 3'd4;  // port 0 has top priority after reset
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            last_winner <= last_winner_next;
        end
    end

    // Credit counter: a simultaneous forward and return cancel out. A return
    // at the ceiling with no forward is a protocol error and is recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits    <= 4'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            case ({fwd, credit_in})
                2'b10: credits <= credits - 4'd1;
                2'b01: begin
                    if (credits == 4'(CREDITS)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credits <= credits + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_WATCHDOG_EN
    // Counts consecutive locked cycles where the owner has nothing to send.
    // Reaching TIMEOUT releases the lock on the following cycle; credits are
    // left as they are because flits already sent still occupy the buffer.
    logic [11:0] wd_cnt;

    assign wd_fire = busy && (wd_cnt == 12'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= 12'd0;
            drop   <= 1'b0;
        end else begin
            drop <= wd_fire;
            if (!busy || owner_req || wd_fire) begin
                wd_cnt <= 12'd0;
            end else begin
                wd_cnt <= wd_cnt + 12'd1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign drop    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_credit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_credit_arbiter
//
// Directed bench for rr_credit_arbiter (CREDITS=4, TIMEOUT=8). A table of
// per-cycle {inputs, expected outputs} records covers arbitration, rotation,
// credit exhaustion and recovery, credit errors, IDLE filtering and reset
// mid-packet. A hand-written sequence covers the stalled-owner case, whose
// expectation depends on whether ARB_WATCHDOG_EN is defined.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_rr_credit_arbiter;

    localparam int CREDITS = 4;
    localparam int TIMEOUT = 8;

    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] B = 3'b010;
    localparam logic [2:0] T = 3'b100;
    localparam logic [2:0] S = 3'b101;
    localparam logic [14:0] ALLH = 15'b001_001_001_001_001;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic [14:0] flit_id;
    logic        credit_in;
    logic [4:0]  grant;
    logic [2:0]  sel;
    logic        fwd;
    logic [3:0]  credits;
    logic        busy;
    logic        credit_err;
    logic        drop;

    always #5 clk = ~clk;

    rr_credit_arbiter #(
        .CREDITS(CREDITS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .flit_id    (flit_id),
        .credit_in  (credit_in),
        .grant      (grant),
        .sel        (sel),
        .fwd        (fwd),
        .credits    (credits),
        .busy       (busy),
        .credit_err (credit_err),
        .drop       (drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [4:0]  req;
        logic [14:0] fid;
        logic        cin;
        logic [4:0]  g;
        logic [2:0]  sel;
        logic        f;
        logic [3:0]  cr;
        logic        b;
        logic        e;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [4:0] rq, input logic [14:0] fd, input logic ci,
                       input logic [4:0] g, input logic [2:0] s, input logic f,
                       input logic [3:0] cr, input logic b, input logic e);
        vec_t v;
        v.rst = r;  v.req = rq; v.fid = fd; v.cin = ci;
        v.g   = g;  v.sel = s;  v.f   = f;  v.cr  = cr; v.b = b; v.e = e;
        vecs.push_back(v);
    endtask

    function automatic logic [14:0] fl(input int p, input logic [2:0] t);
        logic [14:0] r;
        r = '0;
        r[3*p +: 3] = t;
        return r;
    endfunction

    task automatic drive(input logic r, input logic [4:0] rq, input logic [14:0] fd, input logic ci);
        rst       = r;
        req       = rq;
        flit_id   = fd;
        credit_in = ci;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int         q;
    logic [4:0] oh;

    initial begin
        // ---------------- build vector table ----------------
        //    rst req      flit_id             cin grant     sel  f cr b e
        // reset state
        add(0, 5'b00000, 15'd0,              0, 5'b00000, 3'd0, 0, 4, 0, 0);
        // headers on ports 1 and 3: port 1 wins, port 3 two cycles after tail
        add(0, 5'b01010, fl(1,H)|fl(3,H),    0, 5'b00000, 3'd0, 0, 4, 0, 0);
        add(0, 5'b01010, fl(1,T)|fl(3,H),    0, 5'b00010, 3'd1, 1, 4, 1, 0);
        add(0, 5'b01000, fl(3,H),            0, 5'b00000, 3'd0, 0, 3, 0, 0);
        add(0, 5'b01000, fl(3,T),            1, 5'b01000, 3'd3, 1, 3, 1, 0);  // fwd+credit_in
        add(0, 5'b00000, 15'd0,              1, 5'b00000, 3'd0, 0, 3, 0, 0);
        add(0, 5'b00000, 15'd0,              0, 5'b00000, 3'd0, 0, 4, 0, 0);
        // body / tail flits in IDLE are never granted
        add(0, 5'b00100, fl(2,B),            0, 5'b00000, 3'd0, 0, 4, 0, 0);
        add(0, 5'b10100, fl(2,T)|fl(4,B),    0, 5'b00000, 3'd0, 0, 4, 0, 0);
        // credit_in at full count sets sticky credit_err
        add(0, 5'b00000, 15'd0,              1, 5'b00000, 3'd0, 0, 4, 0, 0);
        add(0, 5'b00000, 15'd0,              0, 5'b00000, 3'd0, 0, 4, 0, 1);
        add(1, 5'b00000, 15'd0,              0, 5'b00000, 3'd0, 0, 4, 0, 1);
        // all five ports with 2-flit packets: grants rotate 0,1,2,3,4,0
        for (int k = 0; k < 6; k++) begin
            q  = k % 5;
            oh = 5'b00001 << q;
            add(0, 5'b11111, ALLH, 0, 5'b00000, 3'd0, 0, 4, 0, 0);
            add(0, 5'b11111, ALLH, 1, oh, 3'(q), 1, 4, 1, 0);
            add(0, 5'b11111, (ALLH & ~fl(q, 3'b111)) | fl(q, T), 1, oh, 3'(q), 1, 4, 1, 0);
        end
        add(0, 5'b00000, 15'd0,              0, 5'b00000, 3'd0, 0, 4, 0, 0);
        // 6-flit packet on port 2 with no credit returns
        add(0, 5'b00100, fl(2,H),            0, 5'b00000, 3'd0, 0, 4, 0, 0);
        add(0, 5'b00100, fl(2,H),            0, 5'b00100, 3'd2, 1, 4, 1, 0);
        add(0, 5'b00100, fl(2,B),            0, 5'b00100, 3'd2, 1, 3, 1, 0);
        add(0, 5'b00100, fl(2,B),            0, 5'b00100, 3'd2, 1, 2, 1, 0);
        add(0, 5'b00100, fl(2,B),            0, 5'b00100, 3'd2, 1, 1, 1, 0);
        add(0, 5'b00100, fl(2,B),            0, 5'b00100, 3'd2, 0, 0, 1, 0);
        add(0, 5'b00100, fl(2,B),            0, 5'b00100, 3'd2, 0, 0, 1, 0);
        add(0, 5'b00100, fl(2,B),            1, 5'b00100, 3'd2, 0, 0, 1, 0);
        add(0, 5'b00100, fl(2,B),            0, 5'b00100, 3'd2, 1, 1, 1, 0);  // exactly one more
        add(0, 5'b00100, fl(2,T),            1, 5'b00100, 3'd2, 0, 0, 1, 0);
        add(0, 5'b00000, 15'd0,              1, 5'b00100, 3'd2, 0, 1, 1, 0);
        add(0, 5'b00100, fl(2,T),            1, 5'b00100, 3'd2, 1, 2, 1, 0);  // fwd+cin at 2
        add(0, 5'b00000, 15'd0,              0, 5'b00000, 3'd0, 0, 2, 0, 0);
        // reset in the middle of a packet on port 0
        add(0, 5'b00001, fl(0,H),            1, 5'b00000, 3'd0, 0, 2, 0, 0);
        add(0, 5'b00001, fl(0,H),            0, 5'b00001, 3'd0, 1, 3, 1, 0);
        add(1, 5'b00001, fl(0,B),            0, 5'b00001, 3'd0, 1, 2, 1, 0);
        add(0, 5'b00001, fl(0,B),            0, 5'b00000, 3'd0, 0, 4, 0, 0);
        add(0, 5'b00000, 15'd0,              0, 5'b00000, 3'd0, 0, 4, 0, 0);
        // single-flit packet on port 3
        add(0, 5'b01000, fl(3,S),            0, 5'b00000, 3'd0, 0, 4, 0, 0);
        add(0, 5'b01000, fl(3,S),            0, 5'b01000, 3'd3, 1, 4, 1, 0);
        add(0, 5'b00000, 15'd0,              0, 5'b00000, 3'd0, 0, 3, 0, 0);

        // ---------------- reset ----------------
        drive(1, 5'b00000, 15'd0, 0);
        next_cycle();
        next_cycle();

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].fid, vecs[i].cin);
            #4;
            check($sformatf("v%0d grant", i),      32'(grant),      32'(vecs[i].g));
            check($sformatf("v%0d sel", i),        32'(sel),        32'(vecs[i].sel));
            check($sformatf("v%0d fwd", i),        32'(fwd),        32'(vecs[i].f));
            check($sformatf("v%0d credits", i),    32'(credits),    32'(vecs[i].cr));
            check($sformatf("v%0d busy", i),       32'(busy),       32'(vecs[i].b));
            check($sformatf("v%0d credit_err", i), 32'(credit_err), 32'(vecs[i].e));
            check($sformatf("v%0d drop", i),       32'(drop),       32'd0);
            next_cycle();
        end

        // ---------------- stalled owner ----------------
        drive(1, 5'b00000, 15'd0, 0);
        next_cycle();
        drive(0, 5'b10010, fl(1,H)|fl(4,H), 0);
        #4;
        check("stall arb grant", 32'(grant), 32'd0);
        next_cycle();
        #4;
        check("stall lock grant", 32'(grant), 32'(5'b00010));
        check("stall lock fwd",   32'(fwd),   32'd1);
        next_cycle();
        // owner 1 withdraws; port 4 keeps offering a header
        for (int k = 0; k <= 10; k++) begin
            drive(0, 5'b10000, fl(4,H), 0);
            #4;
`ifdef ARB_WATCHDOG_EN
            if (k <= 8) begin
                check($sformatf("wd s%0d grant", k), 32'(grant), 32'(5'b00010));
                check($sformatf("wd s%0d drop", k),  32'(drop),  32'd0);
                check($sformatf("wd s%0d fwd", k),   32'(fwd),   32'd0);
            end else if (k == 9) begin
                check("wd release grant",   32'(grant),   32'd0);
                check("wd release drop",    32'(drop),    32'd1);
                check("wd release busy",    32'(busy),    32'd0);
                check("wd release credits", 32'(credits), 32'd3);
            end else begin
                check("wd rearb grant", 32'(grant), 32'(5'b10000));
                check("wd rearb drop",  32'(drop),  32'd0);
                check("wd rearb fwd",   32'(fwd),   32'd1);
            end
`else
            check($sformatf("hold s%0d grant", k), 32'(grant), 32'(5'b00010));
            check($sformatf("hold s%0d busy", k),  32'(busy),  32'd1);
            check($sformatf("hold s%0d drop", k),  32'(drop),  32'd0);
            check($sformatf("hold s%0d fwd", k),   32'(fwd),   32'd0);
`endif
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
